// File: rtl/ofdm_symbol_sequencer.sv
// rtl/ofdm_symbol_sequencer.sv - 8-subcarrier OFDM modulator controller: symbol packing, latency wait, sample emission (optional cyclic prefix via OFDM_CP_EN)
module ofdm_symbol_sequencer #(
    parameter int INPUT_WIDTH  = 4,
    parameter int OUTPUT_WIDTH = 16,
    parameter int MOD_LATENCY  = 2,
    parameter int CP_LEN       = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sym_in_valid,
    input  logic [INPUT_WIDTH-1:0]         sym_in_data,
    output logic                           sym_in_ready,
    output logic [8*INPUT_WIDTH-1:0]       mod_data_in,
    input  logic [8*OUTPUT_WIDTH-1:0]      mod_y_re,
    input  logic [8*OUTPUT_WIDTH-1:0]      mod_y_im,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [OUTPUT_WIDTH-1:0] out_re,
    output logic signed [OUTPUT_WIDTH-1:0] out_im,
    output logic                           out_last,
    output logic [15:0]                    frame_count
);

    localparam int NSC = 8;

`ifdef OFDM_CP_EN
    localparam int PREFIX_LEN = CP_LEN;
`else
    // Prefix disabled: CP_LEN stays in the parameter list but has no effect.
    localparam int PREFIX_LEN = CP_LEN * 0;
`endif

    // First emitted slot: 8-PREFIX_LEN with a prefix, otherwise slot 0.
    localparam logic [2:0] START_IDX = 3'((NSC - PREFIX_LEN) % NSC);
    localparam logic       PREFIX_ON = (PREFIX_LEN > 0);

    typedef enum logic [1:0] {
        S_FILL,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t                          state;
    logic [2:0]                      fill_idx;
    logic [2:0]                      emit_idx;
    logic [3:0]                      lat_cnt;
    logic                            in_prefix;
    logic [8*INPUT_WIDTH-1:0]        fill_word;
    logic [8*INPUT_WIDTH-1:0]        fill_next;
    logic signed [OUTPUT_WIDTH-1:0]  cap_re [NSC];
    logic signed [OUTPUT_WIDTH-1:0]  cap_im [NSC];
    logic [2:0]                      next_idx;
    logic                            next_prefix;
    logic                            sym_hs;
    logic                            out_hs;

    // Ready only in FILL, and forced low while reset is asserted.
    assign sym_in_ready = (state == S_FILL) && !reset;
    assign sym_hs       = sym_in_valid && sym_in_ready;
    assign out_hs       = out_valid && out_ready;

    // Fill word with the incoming nibble merged into the current slot.
    always_comb begin
        fill_next = fill_word;
        fill_next[INPUT_WIDTH*fill_idx +: INPUT_WIDTH] = sym_in_data;
    end

    // Next emit slot: the prefix runs up to slot 7, then wraps once into the body.
    always_comb begin
        next_idx    = emit_idx + 3'd1;
        next_prefix = in_prefix;
        if (in_prefix && (emit_idx == 3'd7)) begin
            next_idx    = 3'd0;
            next_prefix = 1'b0;
        end
    end

    // Controller FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FILL;
            fill_idx    <= 3'd0;
            emit_idx    <= 3'd0;
            lat_cnt     <= 4'd0;
            in_prefix   <= 1'b0;
            fill_word   <= '0;
            mod_data_in <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_re      <= '0;
            out_im      <= '0;
            frame_count <= 16'd0;
            for (int k = 0; k < NSC; k++) begin
                cap_re[k] <= '0;
                cap_im[k] <= '0;
            end
        end else begin
            case (state)
                S_FILL: begin
                    if (sym_hs) begin
                        fill_word <= fill_next;
                        if (fill_idx == 3'd7) begin
                            mod_data_in <= fill_next;
                            fill_idx    <= 3'd0;
                            lat_cnt     <= 4'(MOD_LATENCY);
                            state       <= S_WAIT;
                        end else begin
                            fill_idx <= fill_idx + 3'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (lat_cnt <= 4'd1) begin
                        // Modulator outputs are valid at this edge; freeze them.
                        lat_cnt <= 4'd0;
                        for (int k = 0; k < NSC; k++) begin
                            cap_re[k] <= $signed(mod_y_re[OUTPUT_WIDTH*k +: OUTPUT_WIDTH]);
                            cap_im[k] <= $signed(mod_y_im[OUTPUT_WIDTH*k +: OUTPUT_WIDTH]);
                        end
                        emit_idx  <= START_IDX;
                        in_prefix <= PREFIX_ON;
                        out_re    <= $signed(mod_y_re[OUTPUT_WIDTH*START_IDX +: OUTPUT_WIDTH]);
                        out_im    <= $signed(mod_y_im[OUTPUT_WIDTH*START_IDX +: OUTPUT_WIDTH]);
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        state     <= S_EMIT;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                S_EMIT: begin
                    if (out_hs) begin
                        if (out_last) begin
                            frame_count <= frame_count + 16'd1;
                            out_valid   <= 1'b0;
                            out_last    <= 1'b0;
                            emit_idx    <= 3'd0;
                            in_prefix   <= 1'b0;
                            state       <= S_FILL;
                        end else begin
                            emit_idx  <= next_idx;
                            in_prefix <= next_prefix;
                            out_re    <= cap_re[next_idx];
                            out_im    <= cap_im[next_idx];
                            out_last  <= !next_prefix && (next_idx == 3'd7);
                        end
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_ofdm_symbol_sequencer.sv
// tb/tb_ofdm_symbol_sequencer.sv - self-checking bench for ofdm_symbol_sequencer
module tb_ofdm_symbol_sequencer;

`ifdef OFDM_CP_EN
    localparam int NB = 10;
`else
    localparam int NB = 8;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                sym_in_valid;
    logic [3:0]          sym_in_data;
    logic                sym_in_ready;
    logic [31:0]         mod_data_in;
    logic [127:0]        mod_y_re;
    logic [127:0]        mod_y_im;
    logic                out_valid;
    logic                out_ready;
    logic signed [15:0]  out_re;
    logic signed [15:0]  out_im;
    logic                out_last;
    logic [15:0]         frame_count;

    ofdm_symbol_sequencer #(
        .INPUT_WIDTH (4),
        .OUTPUT_WIDTH(16),
        .MOD_LATENCY (2),
        .CP_LEN      (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sym_in_valid(sym_in_valid),
        .sym_in_data (sym_in_data),
        .sym_in_ready(sym_in_ready),
        .mod_data_in (mod_data_in),
        .mod_y_re    (mod_y_re),
        .mod_y_im    (mod_y_im),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_re      (out_re),
        .out_im      (out_im),
        .out_last    (out_last),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ready;
        int   k;
        logic last;
    } beat_t;

    beat_t frame_tab [NB];
    beat_t stall_tab [2*NB-1];
    int    seq_k     [NB];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Stub modulator outputs: Y_k_re = scale*k, Y_k_im = -scale*k.
    task automatic set_stub(input int scale);
        for (int k = 0; k < 8; k++) begin
            mod_y_re[16*k +: 16] = 16'(scale * k);
            mod_y_im[16*k +: 16] = 16'(-scale * k);
        end
    endtask

    // Present 8 nibbles (slot i at nibs[4i+:4]) with gaps[4i+:4] idle cycles after each.
    task automatic feed(input logic [31:0] nibs, input logic [31:0] gaps);
        for (int i = 0; i < 8; i++) begin
            chk("feed_ready", longint'(sym_in_ready), 1);
            sym_in_valid = 1'b1;
            sym_in_data  = nibs[4*i +: 4];
            @(negedge clk);
            sym_in_valid = 1'b0;
            repeat (int'(gaps[4*i +: 4])) @(negedge clk);
        end
    endtask

    // Called in cycle 1 after the slot-7 edge; ends in the first output cycle.
    task automatic wait_first_out();
        chk("lat_cycle1_valid", longint'(out_valid), 0);
        @(negedge clk);
        chk("lat_cycle2_valid", longint'(out_valid), 0);
        @(negedge clk);
        chk("lat_cycle3_valid", longint'(out_valid), 1);
    endtask

    task automatic run_frame();
        for (int i = 0; i < NB; i++) begin
            chk("emit_valid", longint'(out_valid), 1);
            chk("emit_re", longint'(out_re), longint'(100 * frame_tab[i].k));
            chk("emit_im", longint'(out_im), longint'(-100 * frame_tab[i].k));
            chk("emit_last", longint'(out_last), longint'(frame_tab[i].last));
            out_ready = frame_tab[i].ready;
            @(negedge clk);
        end
        chk("post_frame_valid", longint'(out_valid), 0);
        chk("post_frame_ready", longint'(sym_in_ready), 1);
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;

`ifdef OFDM_CP_EN
        seq_k = '{6, 7, 0, 1, 2, 3, 4, 5, 6, 7};
`else
        seq_k = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        for (int i = 0; i < NB; i++) begin
            frame_tab[i].ready = 1'b1;
            frame_tab[i].k     = seq_k[i];
            frame_tab[i].last  = (i == NB - 1);
        end
        // Ready toggles 1,0,1,0...: beat b is shown in cycles 2b-1 (stalled) and 2b.
        for (int c = 0; c < 2*NB-1; c++) begin
            stall_tab[c].ready = (c % 2 == 0);
            stall_tab[c].k     = seq_k[(c + 1) / 2];
            stall_tab[c].last  = ((c + 1) / 2 == NB - 1);
        end

        // Reset held for 5 cycles
        reset        = 1'b1;
        sym_in_valid = 1'b0;
        sym_in_data  = 4'h0;
        out_ready    = 1'b0;
        set_stub(100);
        repeat (5) begin
            @(negedge clk);
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_out_last", longint'(out_last), 0);
            chk("rst_out_re", longint'(out_re), 0);
            chk("rst_sym_ready", longint'(sym_in_ready), 0);
            chk("rst_mod_data", longint'(mod_data_in), 0);
            chk("rst_frame_count", longint'(frame_count), 0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("rel_sym_ready", longint'(sym_in_ready), 1);
        chk("rel_frame_count", longint'(frame_count), 0);

        // Basic frame: nibbles 1..8 back-to-back
        feed(32'h87654321, 32'h0);
        chk("basic_mod_data", longint'(mod_data_in), longint'(32'h87654321));
        wait_first_out();
        run_frame();
        chk("basic_frame_count", longint'(frame_count), 1);

        // Backpressure with 0xF nibbles pending on the input
        feed(32'h87654321, 32'h0);
        sym_in_valid = 1'b1;
        sym_in_data  = 4'hF;
        chk("stall_wait_ready", longint'(sym_in_ready), 0);
        wait_first_out();
        for (int c = 0; c < 2*NB-1; c++) begin
            chk("stall_valid", longint'(out_valid), 1);
            chk("stall_re", longint'(out_re), longint'(100 * stall_tab[c].k));
            chk("stall_im", longint'(out_im), longint'(-100 * stall_tab[c].k));
            chk("stall_last", longint'(out_last), longint'(stall_tab[c].last));
            chk("stall_sym_ready", longint'(sym_in_ready), 0);
            chk("stall_mod_data", longint'(mod_data_in), longint'(32'h87654321));
            out_ready = stall_tab[c].ready;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("stall_end_valid", longint'(out_valid), 0);
        chk("stall_frame_count", longint'(frame_count), 2);
        chk("stall_fill_ready", longint'(sym_in_ready), 1);
        repeat (7) @(negedge clk);
        chk("fill_after_7", longint'(sym_in_ready), 1);
        @(negedge clk);
        sym_in_valid = 1'b0;
        chk("fill_after_8", longint'(sym_in_ready), 0);
        chk("fill_f_mod_data", longint'(mod_data_in), longint'(32'hFFFFFFFF));
        out_ready = 1'b1;
        cyc = 0;
        while (!(out_valid && out_last) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("drain_timeout", longint'(cyc < 40), 1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("drain_frame_count", longint'(frame_count), 3);

        // Reset in the middle of emission
        feed(32'h87654321, 32'h0);
        wait_first_out();
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_beat3_re", longint'(out_re), longint'(100 * seq_k[3]));
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", longint'(out_valid), 0);
        chk("mid_rst_frame_count", longint'(frame_count), 0);
        chk("mid_rst_re", longint'(out_re), 0);
        chk("mid_rst_mod_data", longint'(mod_data_in), 0);
        chk("mid_rst_sym_ready", longint'(sym_in_ready), 0);
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rel_sym_ready", longint'(sym_in_ready), 1);
        chk("mid_rel_valid", longint'(out_valid), 0);
        feed(32'h87654321, 32'h0);
        chk("refeed_mod_data", longint'(mod_data_in), longint'(32'h87654321));
        wait_first_out();
        run_frame();
        chk("refeed_frame_count", longint'(frame_count), 1);

        // Gapped input and stub outputs changing after the capture edge
        feed(32'h4321DCBA, 32'h01321321);
        chk("gap_mod_data", longint'(mod_data_in), longint'(32'h4321DCBA));
        wait_first_out();
        set_stub(37);
        run_frame();
        chk("gap_frame_count", longint'(frame_count), 2);
        chk("gap_mod_data_hold", longint'(mod_data_in), longint'(32'h4321DCBA));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
